// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-clock frame driven on device clocks,
// acknowledge check, and done/error reporting with an overall transfer timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  lvl_q, fall_q;

  state_t                state_q;
  logic [9:0]            shift_q;
  logic [3:0]            bitcnt_q;
  logic [INH_W-1:0]      inh_q;
  logic [TO_W-1:0]       to_q, to_d;
  logic                  ack_q;
  logic                  to_expired;

  // Lines idle high, so synchronizers and the deglitch filter come out of reset at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= '1;
      lvl_q    <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
      filt_q   <= {filt_q[FILTER_LEN-2:0], clk_s2_q};
      if (filt_q == '0) begin
        lvl_q <= 1'b0;
      end else if (filt_q == '1) begin
        lvl_q <= 1'b1;
      end
      fall_q <= lvl_q && (filt_q == '0);
    end
  end

  always_comb begin
    to_d       = to_q + 1'b1;
    to_expired = (to_d == TO_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '1;
      bitcnt_q    <= '0;
      inh_q       <= '0;
      to_q        <= '0;
      ack_q       <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          busy        <= 1'b0;
          if (tx_start) begin
            shift_q    <= {1'b1, ~^tx_data, tx_data};
            bitcnt_q   <= '0;
            inh_q      <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state_q    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_q == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            to_q        <= '0;
            state_q     <= S_START;
          end else begin
            inh_q <= inh_q + 1'b1;
          end
        end
        S_START, S_SHIFT, S_ACK, S_WAIT_IDLE: begin
          to_q <= to_d;
          if (to_expired) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_error    <= 1'b1;
            state_q     <= S_IDLE;
          end else if (state_q == S_ACK) begin
            if (ack_q) begin
              busy     <= 1'b0;
              tx_error <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_WAIT_IDLE;
            end
          end else if (state_q == S_WAIT_IDLE) begin
            if (lvl_q && dat_s2_q) begin
              busy    <= 1'b0;
              tx_done <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (fall_q) begin
            // Falls 1..10 put frame bits out; the 11th is the device acknowledge clock.
            if (state_q == S_SHIFT && bitcnt_q == 4'd10) begin
              ack_q   <= dat_s2_q;
              state_q <= S_ACK;
            end else begin
              ps2_data_oe <= ~shift_q[0];
              shift_q     <= {1'b1, shift_q[9:1]};
              bitcnt_q    <= bitcnt_q + 1'b1;
              state_q     <= S_SHIFT;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, scoreboard of expected frames/outcomes,
// and directed plus randomized transfers.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int FL   = 8;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .tx_done(tx_done), .tx_error(tx_error)
  );

  typedef struct {
    logic [9:0] frame;
    bit         is_err;
    bit         chk_frame;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] cap_frame = '0;
  int         run_cnt = 0;
  int         last_inh = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line levels in transmit order: d0..d7, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  always @(negedge clk) begin
    if (ps2_clk_oe) run_cnt++;
    else if (run_cnt != 0) begin
      last_inh = run_cnt;
      run_cnt  = 0;
    end
    if (rst_n && (tx_done || tx_error)) begin
      check("done_error_exclusive", {31'b0, tx_done & tx_error}, 0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b with no transfer pending", tx_done, tx_error);
      end else begin
        mon_e = sb_q.pop_front();
        check("outcome_error", {31'b0, tx_error}, {31'b0, mon_e.is_err});
        check("outcome_done", {31'b0, tx_done}, {31'b0, !mon_e.is_err});
        check("busy_low_at_end", {31'b0, busy}, 0);
        if (mon_e.chk_frame) check("frame", {22'b0, cap_frame}, {22'b0, mon_e.frame});
      end
    end
  end

  // Device: waits for request-to-send, clocks npulses, samples data on rising edges.
  task automatic device(input bit ack, input bit glitch, input int npulses);
    int w = 0;
    cap_frame = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) begin
      checks++;
      errors++;
      $display("FAIL device_rts_wait: no request-to-send after %0d cycles", w);
      return;
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < npulses; k++) begin
      if (k == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k < 10) cap_frame[k] = ps2_data_in;
      if (glitch && k == 4) begin
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 14) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] d, input bit expect_accept);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    if (expect_accept) begin
      check("busy_after_accept", {31'b0, busy}, 1);
      check("clk_oe_after_accept", {31'b0, ps2_clk_oe}, 1);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("busy_released", {31'b0, busy}, 0);
    repeat (5) @(negedge clk);
    check("lines_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  task automatic transfer(input logic [7:0] d, input bit ack, input bit glitch);
    exp_t e;
    e.frame     = ref_frame(d);
    e.is_err    = !ack;
    e.chk_frame = 1'b1;
    sb_q.push_back(e);
    start_tx(d, 1'b1);
    device(ack, glitch, 11);
    wait_idle();
    check("inhibit_len", last_inh, INH);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cnt;
    bit   seen;

    repeat (3) @(negedge clk);
    check("rst_clk_oe", {31'b0, ps2_clk_oe}, 0);
    check("rst_data_oe", {31'b0, ps2_data_oe}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, tx_done}, 0);
    check("rst_error", {31'b0, tx_error}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    transfer(8'hED, 1'b1, 1'b0);
    transfer(8'hF4, 1'b1, 1'b0);
    transfer(8'h00, 1'b0, 1'b0);
    transfer(8'h3C, 1'b1, 1'b1);

    // Request while busy must not disturb the frame in flight.
    e.frame = ref_frame(8'hED); e.is_err = 1'b0; e.chk_frame = 1'b1;
    sb_q.push_back(e);
    start_tx(8'hED, 1'b1);
    fork
      device(1'b1, 1'b0, 11);
      begin
        repeat (300) @(negedge clk);
        check("busy_mid_transfer", {31'b0, busy}, 1);
        start_tx(8'hAA, 1'b0);
      end
    join
    wait_idle();
    repeat (INH + 20) @(negedge clk);
    check("no_restart_after_ignored", {30'b0, busy, ps2_clk_oe}, 0);

    // Silent device: timeout measured from START entry.
    e.frame = '0; e.is_err = 1'b1; e.chk_frame = 1'b0;
    sb_q.push_back(e);
    start_tx(8'h5A, 1'b1);
    seen = 1'b0;
    for (int w = 0; w < INH + 100; w++) begin
      @(posedge clk); #1;
      if (ps2_data_oe) begin seen = 1'b1; break; end
    end
    check("start_entered", {31'b0, seen}, 1);
    cnt = 0;
    while (!tx_error && cnt < TO + 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("timeout_cycles", cnt, TO);
    check("timeout_data_released", {31'b0, ps2_data_oe}, 0);
    wait_idle();

    // Asynchronous reset in the middle of SHIFT (0x96: d3 = 0, so data is pulled low).
    start_tx(8'h96, 1'b1);
    device(1'b1, 1'b0, 4);
    check("shift_d3_driven", {31'b0, ps2_data_oe}, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_lines", {30'b0, ps2_clk_oe, ps2_data_oe}, 0);
    check("async_rst_busy", {31'b0, busy}, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("after_rst_idle", {29'b0, busy, tx_done, tx_error}, 0);

    for (int i = 0; i < 6; i++) begin
      transfer(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    cnt = 0;
    while (sb_q.size() != 0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
